nv_nvdla_cmac_core_mac_sched: RTL and testbench
===============================================

// Module: nv_nvdla_cmac_core_mac_sched
// PURPOSE
//  Sequencer for the bank of CMAC MAC cells in one CMAC core. Accepts weight-load and data-issue beats from the
//  CMAC input stage and drives per-cell weight-load strobes and the broadcast data-valid strobe.
//  Throttles issue against credits from the accumulator (CACC) and tags each MAC result with stripe/layer flags,
//  time-aligned to the MAC output retiming. Carries control only; operand/result data bypass this block.
// PARAMETERS
//  MAC_NUM      8   MAC cells in the core (one output partial sum each)
//  OUT_RETIMING 3   MAC output retiming stages (cycles from mac_dat_pvld to mac_out_data valid)
//  CREDIT_MAX   16  CACC entries; initial and maximum credit count
//  CNT_W        5   width of credit and in-flight counters (>= clog2(CREDIT_MAX+1))
// PORTS
//  nvdla_core_clk    in  1        core clock
//  nvdla_core_rstn   in  1        asynchronous active-low reset
//  cfg_op_en         in  1        layer enable (level); IDLE exits only while high
//  wt_in_pvld        in  1        weight beat valid
//  wt_in_prdy        out 1        weight beat ready
//  wt_in_sel         in  MAC_NUM  one-hot target cell of the weight beat
//  wt_in_last        in  1        last weight beat of the kernel group
//  dat_in_pvld       in  1        data beat valid
//  dat_in_prdy       out 1        data beat ready
//  dat_in_stripe_st  in  1        first beat of a stripe
//  dat_in_stripe_end in  1        last beat of a stripe
//  dat_in_layer_end  in  1        last beat of the layer (qualified by stripe_end)
//  mac_wt_load       out MAC_NUM  per-cell weight-capture strobe
//  mac_dat_pvld      out 1        broadcast data-valid to all cells
//  acc_credit_vld    in  1        one credit returned by CACC
//  out_pvld          out 1        MAC results valid this cycle (aligned to mac_out_data)
//  out_mask          out MAC_NUM  cells holding valid weights for this result
//  out_stripe_st     out 1        tag: stripe start
//  out_stripe_end    out 1        tag: stripe end
//  out_layer_end     out 1        tag: layer end
//  layer_done        out 1        one-cycle pulse when the layer has fully drained
//  sched_err         out 1        sticky error (non-one-hot sel, credit overflow); cleared by reset only
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; credit=CREDIT_MAX; inflight=0; loaded_mask=0.
//  - FSM: IDLE -> LOAD when cfg_op_en. LOAD: wt_in_prdy=1; each accepted beat: mac_wt_load=wt_in_sel
//    registered (cycle T accept -> strobe at T+1), loaded_mask|=sel; accepting wt_in_last -> RUN.
//    RUN: dat_in_prdy = (credit!=0). Accept at T -> mac_dat_pvld=1 at T+1. Accepting stripe_end with
//    layer_end=0 -> LOAD with loaded_mask cleared; with layer_end=1 -> DRAIN. DRAIN: wait inflight==0 ->
//    layer_done pulse in the same cycle as the IDLE transition.
//  - wt_in_prdy=0 outside LOAD; dat_in_prdy=0 outside RUN. Mid-stripe cfg_op_en deassertion is ignored;
//    it gates IDLE exit only.
//  - Tags: {1, loaded_mask, stripe_st, stripe_end, layer_end} captured with mac_dat_pvld, delayed
//    OUT_RETIMING cycles -> out_* asserted at T+1+OUT_RETIMING. Back-to-back issue yields back-to-back outs.
//  - inflight: +1 on issue, -1 on out_pvld, unchanged when both occur in the same cycle.
//  - credit: -1 on data accept, +1 on acc_credit_vld, unchanged when both. A return at credit==CREDIT_MAX
//    holds credit and sets sched_err.
//  - wt_in_sel not one-hot (zero or multi-bit): beat is still accepted and strobed; sched_err set.
//  - Async reset mid-layer aborts immediately: tag pipe flushed, no layer_done, credit restored to CREDIT_MAX.
// STRUCTURE
//  - Package nv_nvdla_cmac_pkg: FSM state enum (IDLE/LOAD/RUN/DRAIN), tag struct
//    {vld, mask[MAC_NUM], stripe_st, stripe_end, layer_end}, MAC_NUM/OUT_RETIMING/CREDIT_MAX defaults.
//  - Sub-module nv_nvdla_cmac_tag_pipe: parameterised OUT_RETIMING-deep shift register of the tag struct,
//    async reset of the valid bit only.
// TESTING
//  - Reset/idle: cfg_op_en=0, drive wt/dat beats -> both prdy=0, all outputs 0, no state change.
//  - Basic layer: 8 weight beats sel=1<<i (last on i=7), then 4 data beats (stripe_st on 1st,
//    stripe_end+layer_end on 4th) -> 4 mac_dat_pvld; out_pvld at issue+3 with out_mask=8'hFF; layer_done 1 cycle
//    after the last out_pvld.
//  - Credit stall: CREDIT_MAX=16, no returns, 20 data beats offered -> exactly 16 accepted, prdy low;
//    1 acc_credit_vld -> 1 more accepted; simultaneous accept+return keeps credit unchanged.
//  - Multi-stripe: stripe_end without layer_end -> back to LOAD, 3 weight beats (cells 0..2) -> next stripe's
//    out_mask=8'h07.
//  - Errors: sel=8'h03 -> both cells strobed, sched_err=1; extra credit return at full -> credit stays 16, sched_err=1.
//  - Mid-layer reset: assert nvdla_core_rstn low in RUN with 3 in flight -> no out_pvld or layer_done afterwards,
//    credit=16, state IDLE.

Source files
------------

// File: rtl/nv_nvdla_cmac_pkg.sv
// nv_nvdla_cmac_pkg: shared types and defaults for the CMAC MAC scheduler
package nv_nvdla_cmac_pkg;
  localparam int MAC_NUM      = 8;
  localparam int OUT_RETIMING = 3;
  localparam int CREDIT_MAX   = 16;
  localparam int CNT_W        = 5;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} sched_state_e;
  typedef struct packed {
    logic               vld;
    logic [MAC_NUM-1:0] mask;
    logic               stripe_st;
    logic               stripe_end;
    logic               layer_end;
  } mac_tag_t;
  function automatic logic is_onehot(input logic [MAC_NUM-1:0] v);
    return (v != '0) && ((v & (v - MAC_NUM'(1))) == '0);
  endfunction
endpackage

// File: rtl/nv_nvdla_cmac_tag_pipe.sv
// nv_nvdla_cmac_tag_pipe: fixed-latency delay line for MAC result tags
module nv_nvdla_cmac_tag_pipe
  import nv_nvdla_cmac_pkg::*;
#(
  parameter int DEPTH = OUT_RETIMING
) (
  input  logic     nvdla_core_clk,
  input  logic     nvdla_core_rstn,
  input  mac_tag_t din,
  output mac_tag_t dout
);
  logic [DEPTH-1:0] vld;
  mac_tag_t         q [DEPTH];
  // only the valid bit needs reset; payload is qualified by it
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) vld <= '0;
    else begin
      vld[0] <= din.vld;
      for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
    end
  always_ff @(posedge nvdla_core_clk) begin
    q[0] <= din;
    for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
  end
  always_comb begin
    dout     = q[DEPTH-1];
    dout.vld = vld[DEPTH-1];
  end
endmodule

// File: rtl/nv_nvdla_cmac_core_mac_sched.sv
// nv_nvdla_cmac_core_mac_sched: sequences weight loads and credit-throttled data issue for the MAC cells
module nv_nvdla_cmac_core_mac_sched
  import nv_nvdla_cmac_pkg::*;
(
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rstn,
  input  logic               cfg_op_en,
  input  logic               wt_in_pvld,
  output logic               wt_in_prdy,
  input  logic [MAC_NUM-1:0] wt_in_sel,
  input  logic               wt_in_last,
  input  logic               dat_in_pvld,
  output logic               dat_in_prdy,
  input  logic               dat_in_stripe_st,
  input  logic               dat_in_stripe_end,
  input  logic               dat_in_layer_end,
  output logic [MAC_NUM-1:0] mac_wt_load,
  output logic               mac_dat_pvld,
  input  logic               acc_credit_vld,
  output logic               out_pvld,
  output logic [MAC_NUM-1:0] out_mask,
  output logic               out_stripe_st,
  output logic               out_stripe_end,
  output logic               out_layer_end,
  output logic               layer_done,
  output logic               sched_err
);
  sched_state_e       state, state_nxt;
  logic [CNT_W-1:0]   credit, inflight;
  logic [MAC_NUM-1:0] loaded_mask;
  mac_tag_t           tag_q, tag_out;
  logic               wt_acc, dat_acc, credit_ovf, credit_ret;
  assign wt_in_prdy   = state == LOAD;
  assign dat_in_prdy  = state == RUN && credit != '0;
  assign wt_acc       = wt_in_prdy && wt_in_pvld;
  assign dat_acc      = dat_in_prdy && dat_in_pvld;
  assign credit_ovf   = acc_credit_vld && !dat_acc && credit == CNT_W'(CREDIT_MAX);
  assign credit_ret   = acc_credit_vld && !credit_ovf;
  assign mac_dat_pvld = tag_q.vld;
  always_comb begin
    state_nxt  = state;
    layer_done = 1'b0;
    case (state)
      IDLE:    state_nxt = cfg_op_en ? LOAD : IDLE;
      LOAD:    state_nxt = (wt_acc && wt_in_last) ? RUN : LOAD;
      RUN:     state_nxt = (dat_acc && dat_in_stripe_end) ? (dat_in_layer_end ? DRAIN : LOAD) : RUN;
      DRAIN: begin
        layer_done = inflight == '0;
        state_nxt  = layer_done ? IDLE : DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      state       <= IDLE;
      credit      <= CNT_W'(CREDIT_MAX);
      inflight    <= '0;
      loaded_mask <= '0;
      mac_wt_load <= '0;
      tag_q       <= '0;
      sched_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit + CNT_W'(credit_ret) - CNT_W'(dat_acc);
      inflight    <= inflight + CNT_W'(dat_acc) - CNT_W'(tag_out.vld);
      loaded_mask <= (dat_acc && dat_in_stripe_end) ? '0 : wt_acc ? (loaded_mask | wt_in_sel) : loaded_mask;
      mac_wt_load <= wt_acc ? wt_in_sel : '0;
      tag_q       <= {dat_acc, loaded_mask, dat_in_stripe_st, dat_in_stripe_end, dat_in_layer_end};
      sched_err   <= sched_err | (wt_acc && !is_onehot(wt_in_sel)) | credit_ovf;
    end
  // tag_q lines up with mac_dat_pvld; the pipe adds the MAC output retiming
  nv_nvdla_cmac_tag_pipe #(.DEPTH(OUT_RETIMING)) u_tag_pipe (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .din             (tag_q),
    .dout            (tag_out)
  );
  assign out_pvld       = tag_out.vld;
  assign out_mask       = tag_out.vld ? tag_out.mask : '0;
  assign out_stripe_st  = tag_out.vld && tag_out.stripe_st;
  assign out_stripe_end = tag_out.vld && tag_out.stripe_end;
  assign out_layer_end  = tag_out.vld && tag_out.layer_end;
endmodule

// File: tb/tb_nv_nvdla_cmac_core_mac_sched.sv
// tb_nv_nvdla_cmac_core_mac_sched: directed and random checks against a queue-based scheduler model
module tb_nv_nvdla_cmac_core_mac_sched;
  localparam int CMAX = 16;
  localparam int LAT  = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DRAIN = 3;
  logic clk, rstn, op_en, wt_pvld, wt_prdy, wt_last, dat_pvld, dat_prdy;
  logic st, se, le, mac_dat_pvld, credit_vld, out_pvld, out_st, out_se, out_le, layer_done, sched_err;
  logic [7:0] wt_sel, mac_wt_load, out_mask;
  nv_nvdla_cmac_core_mac_sched dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .cfg_op_en(op_en),
    .wt_in_pvld(wt_pvld), .wt_in_prdy(wt_prdy), .wt_in_sel(wt_sel), .wt_in_last(wt_last),
    .dat_in_pvld(dat_pvld), .dat_in_prdy(dat_prdy), .dat_in_stripe_st(st),
    .dat_in_stripe_end(se), .dat_in_layer_end(le), .mac_wt_load(mac_wt_load),
    .mac_dat_pvld(mac_dat_pvld), .acc_credit_vld(credit_vld), .out_pvld(out_pvld),
    .out_mask(out_mask), .out_stripe_st(out_st), .out_stripe_end(out_se),
    .out_layer_end(out_le), .layer_done(layer_done), .sched_err(sched_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {int due; logic [7:0] mask; logic st, se, le;} exp_t;
  exp_t q[$];
  int n_tot, n_bad, cyc, m_mode, m_credit, n_dacc, n_out, n_done;
  logic [7:0] m_mask, m_wl, last_omask;
  logic m_dp, m_err;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    {op_en, wt_pvld, wt_sel, wt_last, dat_pvld, st, se, le, credit_vld} = '0;
    #1;
    chk("rst_ctl", {out_pvld, mac_dat_pvld, layer_done, sched_err, wt_prdy, dat_prdy}, 0);
    chk("rst_vec", {mac_wt_load, out_mask, out_st, out_se, out_le}, 0);
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
    m_mode = M_IDLE; m_credit = CMAX; m_mask = '0; m_wl = '0; m_dp = 1'b0; m_err = 1'b0;
  endtask
  task automatic step(input logic op, input logic wv, input logic [7:0] sel, input logic wl,
                      input logic dv, input logic t_st, input logic t_se, input logic t_le, input logic ret);
    logic ewp, edp, done, wacc, dacc;
    exp_t e;
    @(negedge clk);
    op_en = op; wt_pvld = wv; wt_sel = sel; wt_last = wl;
    dat_pvld = dv; st = t_st; se = t_se; le = t_le; credit_vld = ret;
    #1;
    ewp  = m_mode == M_LOAD;
    edp  = m_mode == M_RUN && m_credit > 0;
    done = m_mode == M_DRAIN && q.size() == 0;
    chk("wt_prdy", wt_prdy, ewp);
    chk("dat_prdy", dat_prdy, edp);
    chk("wt_load", mac_wt_load, m_wl);
    chk("dat_pvld", mac_dat_pvld, m_dp);
    chk("layer_done", layer_done, done);
    chk("sched_err", sched_err, m_err);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("out_pvld", out_pvld, 1);
      chk("out_mask", out_mask, e.mask);
      chk("out_tags", {out_st, out_se, out_le}, {e.st, e.se, e.le});
    end else begin
      chk("out_pvld", out_pvld, 0);
      chk("out_idle", {out_mask, out_st, out_se, out_le}, 0);
    end
    if (dat_prdy && dv) n_dacc++;
    if (out_pvld) begin n_out++; last_omask = out_mask; end
    if (layer_done) n_done++;
    wacc = ewp && wv;
    dacc = edp && dv;
    m_wl = wacc ? sel : 8'h00;
    m_dp = dacc;
    if (wacc) begin
      m_mask |= sel;
      if ($countones(sel) != 1) m_err = 1'b1;
      if (wl) m_mode = M_RUN;
    end
    if (dacc) begin
      q.push_back('{cyc + LAT, m_mask, t_st, t_se, t_le});
      if (t_se) begin m_mask = '0; m_mode = t_le ? M_DRAIN : M_LOAD; end
    end
    if (ret) begin
      if (m_credit == CMAX && !dacc) m_err = 1'b1;
      else m_credit++;
    end
    if (dacc) m_credit--;
    if (m_mode == M_IDLE && op) m_mode = M_LOAD;
    if (done) m_mode = M_IDLE;
    cyc++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic load8();
    for (int i = 0; i < 8; i++) step(1, 1, 8'(1 << i), i == 7, 0, 0, 0, 0, 0);
  endtask
  initial begin
    int b_out, b_done, b_dacc;
    logic [7:0] rsel;
    n_tot = 0; n_bad = 0; cyc = 0; n_dacc = 0; n_out = 0; n_done = 0; last_omask = '0;
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 8'h01, 1, 1, 1, 1, 1, 0);
    b_out = n_out; b_done = n_done;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    load8();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, i == 0, i == 3, i == 3, 0);
    idle(10);
    chk("basic_outs", n_out - b_out, 4);
    chk("basic_done", n_done - b_done, 1);
    chk("basic_mask", last_omask, 8'hFF);
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h01, 1, 0, 0, 0, 0, 0);
    b_dacc = n_dacc;
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("cred_stall", n_dacc - b_dacc, 16);
    step(1, 0, 0, 0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("cred_one", n_dacc - b_dacc, 17);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("cred_both", n_dacc - b_dacc, 19);
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    load8();
    step(1, 0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 8'(1 << i), i == 2, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 1, 1, 0);
    idle(8);
    chk("ms_mask", last_omask, 8'h07);
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h03, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("err_sel", sched_err, 1);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("err_ovf", sched_err, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h01, 1, 0, 0, 0, 0, 0);
    b_dacc = n_dacc;
    for (int i = 0; i < 18; i++) step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("ovf_credit", n_dacc - b_dacc, 16);
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h01, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, i == 0, 0, 0, 0);
    do_reset();
    b_out = n_out; b_done = n_done;
    idle(10);
    chk("rst_no_out", n_out - b_out, 0);
    chk("rst_no_done", n_done - b_done, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h01, 1, 0, 0, 0, 0, 0);
    b_dacc = n_dacc;
    for (int i = 0; i < 18; i++) step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("rst_credit", n_dacc - b_dacc, 16);
    for (int s = 0; s < 8; s++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        rsel = ($urandom % 16 == 0) ? 8'($urandom) : 8'(1 << ($urandom % 8));
        step($urandom % 8 != 0, $urandom % 4 != 0, rsel, $urandom % 6 == 0,
             $urandom % 4 != 0, $urandom % 4 == 0, $urandom % 5 == 0, $urandom % 3 == 0,
             (s % 2 == 0) ? ($urandom % 3 == 0) : ($urandom % 8 == 0));
      end
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
